// File: rtl/dac_segment_encoder_if.sv
// rtl/dac_segment_encoder_if.sv - sample code valid/ready stream into the DAC segment encoder
interface dac_segment_encoder_if;
  logic [10:0] sample_code;
  logic        sample_valid;
  logic        sample_ready;

  modport master (output sample_code, output sample_valid, input sample_ready);
  modport slave  (input sample_code, input sample_valid, output sample_ready);
endinterface

// File: rtl/dac_segment_encoder.sv
// rtl/dac_segment_encoder.sv - power/cal sequencer and 2-stage thermometer+binary split for the segmented DAC
module dac_segment_encoder #(
  parameter int PWRUP_CYCLES      = 64,
  parameter int CAL_SETTLE_CYCLES = 32,
  parameter int THERM_UNITS       = 17
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [4:0]             cal_code,
  input  logic                   red_ena,
  dac_segment_encoder_if.slave   smp,
  output logic                   pdb,
  output logic [6:0]             datain,
  output logic [6:0]             datainb,
  output logic [THERM_UNITS-1:0] datatherm,
  output logic [THERM_UNITS-1:0] datathermb,
  output logic [4:0]             dataical,
  output logic                   running,
  output logic                   ovf
);

  localparam int          CW       = $clog2(PWRUP_CYCLES + CAL_SETTLE_CYCLES + 2);
  localparam logic [10:0] MAX_CODE = 11'd1151;

  typedef enum logic [2:0] {OFF, BIAS_WAIT, CAL_LOAD, RUN, DRAIN} state_t;

  state_t                 state, state_nxt;
  logic [CW-1:0]          cnt, cnt_nxt;
  logic                   accept, flush;
  logic [10:0]            clamped;
  logic [4:0]             m1;
  logic [5:0]             l1;
  logic [THERM_UNITS-1:0] therm_nxt;
  logic [6:0]             din_nxt;

  // BIAS_WAIT spends one extra cycle while pdb is registered high, then PWRUP_CYCLES more
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    case (state)
      OFF: begin
        cnt_nxt = '0;
        if (enable) state_nxt = BIAS_WAIT;
      end
      BIAS_WAIT: begin
        if (!enable)                            state_nxt = DRAIN;
        else if (cnt == CW'(PWRUP_CYCLES))      state_nxt = CAL_LOAD;
      end
      CAL_LOAD: begin
        if (!enable)                            state_nxt = DRAIN;
        else if (cnt == CW'(CAL_SETTLE_CYCLES - 1)) state_nxt = RUN;
      end
      RUN: begin
        cnt_nxt = '0;
        if (!enable) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (cnt == CW'(1)) state_nxt = OFF;
      end
      default: state_nxt = OFF;
    endcase
    if (state_nxt != state) cnt_nxt = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= OFF;
      cnt      <= '0;
      pdb      <= 1'b0;
      running  <= 1'b0;
      dataical <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      pdb      <= (state != OFF) && (state_nxt != OFF);
      running  <= (state_nxt == RUN);
      if (state == BIAS_WAIT && state_nxt == CAL_LOAD) dataical <= cal_code;
    end
  end

  assign smp.sample_ready = (state == RUN) && enable;
  assign accept           = smp.sample_valid && smp.sample_ready;
  assign flush            = (state != RUN) || !enable;
  assign clamped          = (smp.sample_code > MAX_CODE) ? MAX_CODE : smp.sample_code;

  // Stage 1: clamp and split; idle cycles in RUN hold the last code rather than inserting zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m1  <= '0;
      l1  <= '0;
      ovf <= 1'b0;
    end else if (accept) begin
      m1 <= clamped[10:6];
      l1 <= clamped[5:0];
      if (smp.sample_code > MAX_CODE) ovf <= 1'b1;
    end else if (flush) begin
      m1 <= '0;
      l1 <= '0;
    end
  end

  always_comb begin
    therm_nxt = '0;
    for (int i = 0; i < THERM_UNITS; i++) therm_nxt[i] = (i < int'(m1));
    din_nxt = {red_ena, l1};
  end

  // Stage 2: true and complement taken from their own flops so both switch on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      datatherm  <= '0;
      datathermb <= '1;
      datain     <= '0;
      datainb    <= '1;
    end else begin
      datatherm  <= therm_nxt;
      datathermb <= ~therm_nxt;
      datain     <= din_nxt;
      datainb    <= ~din_nxt;
    end
  end

endmodule

// File: tb/tb_dac_segment_encoder.sv
// tb/tb_dac_segment_encoder.sv - scoreboard bench for dac_segment_encoder with random code sweep
module tb_dac_segment_encoder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [4:0]  cal_code;
  logic        red_ena;
  logic        pdb, running, ovf;
  logic [6:0]  datain, datainb;
  logic [16:0] datatherm, datathermb;
  logic [4:0]  dataical;

  dac_segment_encoder_if smp();

  dac_segment_encoder #(.PWRUP_CYCLES(64), .CAL_SETTLE_CYCLES(32), .THERM_UNITS(17)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .cal_code(cal_code), .red_ena(red_ena),
    .smp(smp), .pdb(pdb), .datain(datain), .datainb(datainb), .datatherm(datatherm),
    .datathermb(datathermb), .dataical(dataical), .running(running), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [16:0] q_th[$];
  logic [6:0]  q_di[$];
  logic [16:0] last_th;
  logic [6:0]  last_di;
  bit          have_last = 0;
  bit          hold_chk = 0;
  bit          acc_h0 = 0, acc_h1 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: clamp to 1151, count of 64-LSB units lit, remainder in binary
  task automatic model(input int code, input bit red, output logic [16:0] th, output logic [6:0] di);
    int          c;
    logic [31:0] t;
    c  = (code > 1151) ? 1151 : code;
    t  = (32'd1 << (c / 64)) - 32'd1;
    th = t[16:0];
    di = {red, 6'(c % 64)};
  endtask

  task automatic send(input int code);
    logic [16:0] th;
    logic [6:0]  di;
    smp.sample_code  = 11'(code);
    smp.sample_valid = 1'b1;
    @(negedge clk);
    if (smp.sample_ready) begin
      model(code, red_ena, th, di);
      q_th.push_back(th);
      q_di.push_back(di);
    end
    @(posedge clk);
    #1;
    smp.sample_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      smp.sample_code = 11'($urandom_range(0, 2047));
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: an accept seen before edge N is compared two negedges later (after edge N+1)
  always @(negedge clk) begin
    if (!rst_n) begin
      acc_h0 = 0;
      acc_h1 = 0;
    end else begin
      chk("din_complement", 32'(datain ^ datainb), 32'h7F);
      chk("therm_complement", 32'(datatherm ^ datathermb), 32'h1FFFF);
      if (acc_h1) begin
        if (q_th.size() == 0) begin
          chk("sb_underflow", 32'(q_th.size()), 32'd1);
        end else begin
          last_th = q_th.pop_front();
          last_di = q_di.pop_front();
          have_last = 1;
          chk("therm", 32'(datatherm), 32'(last_th));
          chk("din", 32'(datain), 32'(last_di));
        end
      end else if (hold_chk && have_last) begin
        chk("therm_hold", 32'(datatherm), 32'(last_th));
        chk("din_hold", 32'(datain), 32'(last_di));
      end
      acc_h1 = acc_h0;
      acc_h0 = smp.sample_valid && smp.sample_ready;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    enable = 1'b0;
    cal_code = 5'b10110;
    red_ena = 1'b1;
    smp.sample_code = '0;
    smp.sample_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pdb", 32'(pdb), 0);
    chk("rst_running", 32'(running), 0);
    chk("rst_ready", 32'(smp.sample_ready), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_datain", 32'(datain), 0);
    chk("rst_datainb", 32'(datainb), 32'h7F);
    chk("rst_datatherm", 32'(datatherm), 0);
    chk("rst_datathermb", 32'(datathermb), 32'h1FFFF);
    chk("rst_dataical", 32'(dataical), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1 enable = 1'b1;

    // Power-up sequence timed from the edge E that first samples enable
    for (int k = 0; k <= 97; k++) begin
      @(posedge clk);
      #1;
      if (k == 0)  chk("pdb_at_E", 32'(pdb), 0);
      if (k == 1)  chk("pdb_at_E1", 32'(pdb), 1);
      if (k == 64) chk("dataical_before", 32'(dataical), 0);
      if (k == 65) chk("dataical_loaded", 32'(dataical), 32'b10110);
      if (k == 96) chk("ready_before", 32'(smp.sample_ready), 0);
      if (k == 97) begin
        chk("ready_run", 32'(smp.sample_ready), 1);
        chk("running_run", 32'(running), 1);
      end
    end

    hold_chk = 1;
    send(0); send(63); send(64); send(575); send(1151);
    chk("ovf_legal", 32'(ovf), 0);
    send(2047);
    send(100); send(700);
    idle(4);
    chk("ovf_sticky", 32'(ovf), 1);

    repeat (10000) begin
      if ($urandom_range(0, 15) == 0) send($urandom_range(1152, 2047));
      else send($urandom_range(0, 1151));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    n = 0;
    while (q_th.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    #1 chk("sb_drained", 32'(q_th.size()), 0);

    // Drop enable mid-stream; samples already accepted still arrive before the zero code
    send(300); send(900);
    hold_chk = 0;
    enable = 1'b0;
    smp.sample_code = 11'd500;
    smp.sample_valid = 1'b1;
    #1 chk("ready_drop", 32'(smp.sample_ready), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("pdb_drain", 32'(pdb), 1);
    chk("therm_zero", 32'(datatherm), 0);
    chk("din_zero", 32'(datain), 32'h40);
    @(posedge clk);
    #1;
    chk("pdb_off", 32'(pdb), 0);
    chk("running_off", 32'(running), 0);
    chk("din_zero_off", 32'(datain), 32'h40);
    chk("dinb_zero_off", 32'(datainb), 32'h3F);
    chk("thermb_zero_off", 32'(datathermb), 32'h1FFFF);
    smp.sample_valid = 1'b0;
    chk("sb_empty_drain", 32'(q_th.size()), 0);

    // Restart and reset asynchronously while in CAL_LOAD
    cal_code = 5'b01101;
    enable = 1'b1;
    repeat (80) @(posedge clk);
    #1 chk("dataical_reload", 32'(dataical), 32'b01101);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pdb", 32'(pdb), 0);
    chk("arst_dataical", 32'(dataical), 0);
    chk("arst_ovf", 32'(ovf), 0);
    chk("arst_datain", 32'(datain), 0);
    chk("arst_datainb", 32'(datainb), 32'h7F);
    chk("arst_datatherm", 32'(datatherm), 0);
    chk("arst_datathermb", 32'(datathermb), 32'h1FFFF);
    chk("arst_running", 32'(running), 0);
    chk("arst_ready", 32'(smp.sample_ready), 0);
    #20;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
